tpu_host_driver: RTL and testbench
==================================

TPU_HOST_DRIVER -- requirements
Module: tpu_host_driver

Interface
REQ-001 RESULT_LAT, default 4: cycles from the load strobe of the final operand byte to the first result byte on tpu_uo_out; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 op_data  input  8  operand byte, int8, order A00,A01,A10,A11,B00,B01,B10,B11.
REQ-005 op_valid  input  1  op_data valid.
REQ-006 op_ready  output  1  driver accepts operand byte.
REQ-007 res_data  output  16  result word {hi,lo}, order C00,C01,C10,C11.
REQ-008 res_valid  output  1  res_data valid.
REQ-009 res_ready  input  1  consumer accepts result word.
REQ-010 tpu_ui_in  output  8  to TPU ui_in, operand byte.
REQ-011 tpu_uio_in  output  8  to TPU uio_in: bit0 load_en, bit1 mat_sel (0=A, 1=B), bits3:2 element index, bits7:4 zero.
REQ-012 tpu_uo_out  input  8  from TPU uo_out, result byte stream.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 States SHALL be IDLE, LOAD, WAIT, CAPTURE and DRAIN.
REQ-015 op_ready SHALL be high in IDLE and LOAD and low otherwise; a byte is accepted on op_valid && op_ready.
REQ-016 IDLE->LOAD on the first accept; LOAD->WAIT on the 8th accept; the byte counter k runs 0..7.
REQ-017 Accept of byte k in cycle N SHALL produce, in cycle N+1 only: tpu_ui_in=op_data, load_en=1, mat_sel=k[2], index=k[1:0]. In all other cycles load_en=0 and tpu_ui_in=0.
REQ-018 Gaps in op_valid during LOAD SHALL be tolerated: no strobe is emitted and k holds.
REQ-019 With cycle T being the strobe of byte 7, the driver SHALL sample tpu_uo_out at the edges ending cycles T+RESULT_LAT through T+RESULT_LAT+7, giving bytes C00lo, C00hi, C01lo, C01hi, C10lo, C10hi, C11lo, C11hi.
REQ-020 WAIT SHALL use a 4-bit down-counter; CAPTURE SHALL last exactly 8 cycles and then enter DRAIN.
REQ-021 In DRAIN, res_valid=1 and res_data={hi,lo} of the current word; the word index advances on res_valid && res_ready.
REQ-022 After the 4th word handshake the state SHALL return to IDLE, with op_ready high in the next cycle.
REQ-023 res_data SHALL hold stable while res_valid && !res_ready.
REQ-024 op_valid SHALL be ignored in WAIT, CAPTURE and DRAIN; tpu_uo_out SHALL be ignored outside CAPTURE.
REQ-025 Result bytes SHALL be stored unmodified; there is no sign extension or saturation.

Reset
REQ-026 While rst_n=0: state IDLE; counters, buffer and word index cleared; res_valid=0, res_data=0, tpu_ui_in=0, tpu_uio_in=0, busy=0, op_ready=1.
REQ-027 Reset asserted mid-transaction SHALL abandon it; no res_valid or load_en pulse from that transaction SHALL appear after release.

Structure
REQ-028 Package tpu_host_pkg SHALL hold the state enum, NUM_BYTES=8, NUM_WORDS=4 and the uio_in bit positions (LOAD_EN, MAT_SEL, IDX_LSB).
REQ-029 The design SHALL be a single module with no sub-module; the 8x8 capture buffer is inline.

Verification
REQ-030 Test 1, basic transaction, RESULT_LAT=4: bytes 0x01..0x08 back-to-back; TPU model returns 0x11,0x22,...,0x88 at T+4. Required: words 0x2211, 0x4433, 0x6655, 0x8877, then IDLE.
REQ-031 Test 2, strobe encoding: byte k=5 = 0xF0. Required: a one-cycle pulse with tpu_uio_in=0x07 and tpu_ui_in=0xF0, and zeros in the cycles around it.
REQ-032 Test 3, input gaps: op_valid deasserted 2 cycles between every byte. Required: exactly 8 strobes with indices 0..3, 0..3, and the same results as Test 1.
REQ-033 Test 4, backpressure: res_ready low 3 cycles on word 1. Required: res_data holds 0x4433, no words are lost or duplicated, and busy stays high until the 4th handshake.
REQ-034 Test 5, reset mid-operation: rst_n pulsed low in CAPTURE cycle 3. Required: outputs take their reset values immediately; after release op_ready=1 and there is no res_valid; a new transaction then completes correctly.
REQ-035 Test 6, latency edge: RESULT_LAT=1 and RESULT_LAT=15. Required: capture aligns exactly to T+1 and T+15 respectively.

Source files
------------

// File: rtl/tpu_host_driver_pkg.sv
`timescale 1ns/1ps
// tpu_host_pkg
//   Shared definitions for the TPU host driver: FSM state encoding, transfer
//   sizes, data widths and the bit layout of the TPU uio_in control byte.
package tpu_host_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned WORD_W    = 2 * BYTE_W;
    localparam int unsigned NUM_BYTES = 8;   // A00..A11, B00..B11
    localparam int unsigned NUM_WORDS = 4;   // C00..C11

    // uio_in bit positions
    localparam int unsigned LOAD_EN = 0;
    localparam int unsigned MAT_SEL = 1;
    localparam int unsigned IDX_LSB = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_CAPTURE,
        ST_DRAIN
    } state_t;

    // Control byte for the load strobe of operand byte k:
    // k[2] selects matrix A/B, k[1:0] is the element index.
    function automatic logic [BYTE_W-1:0] strobe_ctrl(input logic [2:0] k);
        logic [BYTE_W-1:0] c;
        c                 = '0;
        c[LOAD_EN]        = 1'b1;
        c[MAT_SEL]        = k[2];
        c[IDX_LSB +: 2]   = k[1:0];
        return c;
    endfunction

endpackage

// File: rtl/tpu_host_driver_if.sv
`timescale 1ns/1ps
// tpu_host_driver_if
//   Host-side streams of the TPU host driver.
//   op_data/op_valid/op_ready : operand byte stream into the driver
//   res_data/res_valid/res_ready : result word stream out of the driver
//   master : the host (produces operands, consumes results)
//   slave  : the driver
interface tpu_host_driver_if;
    import tpu_host_pkg::*;

    logic [BYTE_W-1:0] op_data;
    logic              op_valid;
    logic              op_ready;
    logic [WORD_W-1:0] res_data;
    logic              res_valid;
    logic              res_ready;

    modport master (
        output op_data, op_valid, res_ready,
        input  op_ready, res_data, res_valid
    );

    modport slave (
        input  op_data, op_valid, res_ready,
        output op_ready, res_data, res_valid
    );

endinterface

// File: rtl/tpu_host_driver.sv
`timescale 1ns/1ps
// tpu_host_driver
//   Feeds eight int8 operand bytes (A00..A11, B00..B11) into a 2x2 TPU tile
//   one load strobe at a time, waits RESULT_LAT cycles after the last strobe,
//   captures eight result bytes from tpu_uo_out and returns them as four
//   16-bit words {hi,lo} (C00..C11).
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : operand/result streams (slave side)
//   tpu_ui_in    : operand byte to the TPU, valid only during a load strobe
//   tpu_uio_in   : {4'b0, index[1:0], mat_sel, load_en}
//   tpu_uo_out   : result byte stream from the TPU
//   busy         : high whenever the driver is not idle
module tpu_host_driver
    import tpu_host_pkg::*;
#(
    parameter int unsigned RESULT_LAT = 4   // legal range 1..15
) (
    input  logic              clk,
    input  logic              rst_n,
    tpu_host_driver_if.slave  bus,
    output logic [BYTE_W-1:0] tpu_ui_in,
    output logic [BYTE_W-1:0] tpu_uio_in,
    input  logic [BYTE_W-1:0] tpu_uo_out,
    output logic              busy
);

    localparam int unsigned KW = $clog2(NUM_BYTES);
    localparam int unsigned WW = $clog2(NUM_WORDS);

    // WAIT lasts RESULT_LAT cycles, starting with the cycle of the last strobe
    localparam logic [3:0] WAIT_INIT = 4'(RESULT_LAT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [KW-1:0]     k;          // operand count in LOAD, capture slot in CAPTURE
    logic [3:0]        wait_cnt;
    logic [WW-1:0]     word_idx;
    logic [BYTE_W-1:0] cap_buf [NUM_BYTES];
    logic              op_acc;
    logic              res_hs;

    assign op_acc = bus.op_valid && bus.op_ready;
    assign res_hs = bus.res_valid && bus.res_ready;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (op_acc) state_nxt = ST_LOAD;
            ST_LOAD:    if (op_acc && k == KW'(NUM_BYTES - 1)) state_nxt = ST_WAIT;
            ST_WAIT:    if (wait_cnt == '0) state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (k == KW'(NUM_BYTES - 1)) state_nxt = ST_DRAIN;
            ST_DRAIN:   if (res_hs && word_idx == WW'(NUM_WORDS - 1)) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // output logic
    always_comb begin
        bus.op_ready  = (state == ST_IDLE) || (state == ST_LOAD);
        bus.res_valid = (state == ST_DRAIN);
        busy          = (state != ST_IDLE);
        bus.res_data  = '0;
        if (state == ST_DRAIN) begin
            bus.res_data = {cap_buf[{word_idx, 1'b1}], cap_buf[{word_idx, 1'b0}]};
        end
    end

    // Counters and capture buffer. k wraps to zero after the 8th accept and
    // again after the 8th capture, so one counter serves both phases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k        <= '0;
            wait_cnt <= '0;
            word_idx <= '0;
            for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                cap_buf[i] <= '0;
            end
        end else begin
            unique case (state)
                ST_IDLE, ST_LOAD: begin
                    wait_cnt <= WAIT_INIT;
                    if (op_acc) k <= k + 1'b1;
                end
                ST_WAIT: begin
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
                end
                ST_CAPTURE: begin
                    cap_buf[k] <= tpu_uo_out;
                    k          <= k + 1'b1;
                end
                ST_DRAIN: begin
                    if (res_hs) word_idx <= word_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Load strobe: one registered cycle per accepted byte, zeros otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tpu_ui_in  <= '0;
            tpu_uio_in <= '0;
        end else if (op_acc) begin
            tpu_ui_in  <= bus.op_data;
            tpu_uio_in <= strobe_ctrl(k);
        end else begin
            tpu_ui_in  <= '0;
            tpu_uio_in <= '0;
        end
    end

endmodule

// File: tb/tb_tpu_host_driver.sv
`timescale 1ns/1ps
// tb_tpu_host_driver
//   Directed bench for tpu_host_driver. Three instances with RESULT_LAT of
//   4, 1 and 15 share the clock and reset; sel routes stimulus and
//   observation to one of them. A small TPU model per instance answers the
//   strobe of byte 7 with bytes 0x11..0x88 starting exactly RESULT_LAT cycles
//   later and drives 0xEE at all other times.
module tb_tpu_host_driver;
    import tpu_host_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    int         sel = 0;
    logic [7:0] op_data;
    logic       op_valid;
    logic       res_ready;

    logic [7:0] ui0, ui1, ui2, uio0, uio1, uio2;
    logic       busy0, busy1, busy2;
    logic [7:0] uo_m  [3];
    logic [7:0] uio_a [3];
    int         tcnt  [3] = '{-1, -1, -1};

    logic        c_op_ready, c_res_valid, c_busy;
    logic [15:0] c_res_data;
    logic [7:0]  c_ui, c_uio;

    logic [7:0]  tx_b  [8];
    logic [15:0] rx_w  [4];
    int          rx_n;
    logic [15:0] rx_held;
    bit          rx_hold_ok, rx_busy_ok;
    logic [15:0] exp_w [4] = '{16'h2211, 16'h4433, 16'h6655, 16'h8877};

    logic [15:0] tr [$];
    bit          trace_en = 1'b0;

    tpu_host_driver_if if0 ();
    tpu_host_driver_if if1 ();
    tpu_host_driver_if if2 ();

    assign if0.op_data   = op_data;
    assign if1.op_data   = op_data;
    assign if2.op_data   = op_data;
    assign if0.op_valid  = op_valid && (sel == 0);
    assign if1.op_valid  = op_valid && (sel == 1);
    assign if2.op_valid  = op_valid && (sel == 2);
    assign if0.res_ready = (sel == 0) ? res_ready : 1'b1;
    assign if1.res_ready = (sel == 1) ? res_ready : 1'b1;
    assign if2.res_ready = (sel == 2) ? res_ready : 1'b1;

    tpu_host_driver #(.RESULT_LAT(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave), .tpu_ui_in(ui0),
        .tpu_uio_in(uio0), .tpu_uo_out(uo_m[0]), .busy(busy0));
    tpu_host_driver #(.RESULT_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave), .tpu_ui_in(ui1),
        .tpu_uio_in(uio1), .tpu_uo_out(uo_m[1]), .busy(busy1));
    tpu_host_driver #(.RESULT_LAT(15)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.slave), .tpu_ui_in(ui2),
        .tpu_uio_in(uio2), .tpu_uo_out(uo_m[2]), .busy(busy2));

    always_comb begin
        uio_a[0] = uio0;
        uio_a[1] = uio1;
        uio_a[2] = uio2;
    end

    always_comb begin
        case (sel)
            1: begin
                c_op_ready = if1.op_ready; c_res_valid = if1.res_valid; c_res_data = if1.res_data;
                c_ui = ui1; c_uio = uio1; c_busy = busy1;
            end
            2: begin
                c_op_ready = if2.op_ready; c_res_valid = if2.res_valid; c_res_data = if2.res_data;
                c_ui = ui2; c_uio = uio2; c_busy = busy2;
            end
            default: begin
                c_op_ready = if0.op_ready; c_res_valid = if0.res_valid; c_res_data = if0.res_data;
                c_ui = ui0; c_uio = uio0; c_busy = busy0;
            end
        endcase
    end

    // ---------------- TPU model ----------------
    function automatic int lat_of(input int d);
        case (d)
            1:       return 1;
            2:       return 15;
            default: return 4;
        endcase
    endfunction

    // t counts cycles since the strobe of byte 7 (t=0 is cycle T)
    function automatic int next_t(input logic rst, input int cur, input logic [7:0] u, input int lat);
        if (!rst) return -1;
        if (u == 8'h0F) return 0;
        if (cur < 0) return -1;
        if (cur + 1 >= lat + 8) return -1;
        return cur + 1;
    endfunction

    function automatic logic [7:0] tpu_byte(input int t, input int lat);
        if (t >= lat && t < lat + 8) return 8'((t - lat + 1) * 17);
        return 8'hEE;
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            tcnt[d] <= next_t(rst_n, tcnt[d], uio_a[d], lat_of(d));
            uo_m[d] <= tpu_byte(next_t(rst_n, tcnt[d], uio_a[d], lat_of(d)), lat_of(d));
        end
    end

    always @(negedge clk) begin
        if (trace_en) tr.push_back({uio0, ui0});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_default_bytes();
        for (int i = 0; i < 8; i++) tx_b[i] = 8'(i + 1);
    endtask

    task automatic send_txn(input int gap);
        for (int k = 0; k < 8; k++) begin
            op_valid = 1'b1;
            op_data  = tx_b[k];
            tick();
            op_valid = 1'b0;
            op_data  = 8'h5A;
            for (int g = 0; g < gap; g++) tick();
        end
    endtask

    // Drains up to four words; optionally withholds res_ready for stall_cyc
    // cycles while word stall_word is presented.
    task automatic collect(input int stall_word, input int stall_cyc);
        int stall;
        bit held_set;
        stall      = stall_cyc;
        held_set   = 1'b0;
        rx_n       = 0;
        rx_hold_ok = 1'b1;
        rx_busy_ok = 1'b1;
        rx_held    = 16'hxxxx;
        for (int i = 0; i < 4; i++) rx_w[i] = 16'hxxxx;
        for (int c = 0; c < 400 && rx_n < 4; c++) begin
            if (!c_busy) rx_busy_ok = 1'b0;
            if (c_res_valid) begin
                if (rx_n == stall_word && stall > 0) begin
                    res_ready = 1'b0;
                    if (held_set && c_res_data !== rx_held) rx_hold_ok = 1'b0;
                    rx_held  = c_res_data;
                    held_set = 1'b1;
                    stall--;
                end else begin
                    res_ready  = 1'b1;
                    rx_w[rx_n] = c_res_data;
                    rx_n++;
                end
            end else begin
                res_ready = 1'b1;
            end
            tick();
        end
        res_ready = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; op_valid = 1'b0; op_data = 8'h00; res_ready = 1'b1; sel = 0;
        tick(); tick();
        total_cnt++;
        if (c_op_ready !== 1'b1) $display("FAIL reset_op_ready: got %b want 1", c_op_ready); else pass_cnt++;
        total_cnt++;
        if (c_res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b want 0", c_res_valid); else pass_cnt++;
        total_cnt++;
        if (c_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", c_busy); else pass_cnt++;
        total_cnt++;
        if ({c_res_data, c_ui, c_uio} !== 32'h0)
            $display("FAIL reset_data: got res=%h ui=%h uio=%h want 0", c_res_data, c_ui, c_uio);
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        sel = 0;
        set_default_bytes();
        send_txn(0);
        collect(-1, 0);
        total_cnt++;
        if (rx_n !== 4) $display("FAIL basic_count: got %0d words want 4", rx_n); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (rx_w[i] !== exp_w[i]) $display("FAIL basic_word%0d: got %h want %h", i, rx_w[i], exp_w[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (c_busy !== 1'b0) $display("FAIL basic_idle_busy: got %b want 0", c_busy); else pass_cnt++;
        total_cnt++;
        if (c_op_ready !== 1'b1) $display("FAIL basic_idle_op_ready: got %b want 1", c_op_ready); else pass_cnt++;
    endtask

    task automatic test_strobe_encoding();
        int hits, idx;
        logic [15:0] prev_v, next_v;
        sel = 0;
        set_default_bytes();
        tx_b[5] = 8'hF0;
        tr.delete();
        trace_en = 1'b1;
        send_txn(1);
        tick();
        trace_en = 1'b0;
        hits = 0; idx = -1;
        for (int i = 0; i < tr.size(); i++) begin
            if (tr[i] == 16'h07F0) begin hits++; idx = i; end
        end
        prev_v = (idx > 0) ? tr[idx - 1] : 16'hFFFF;
        next_v = (idx >= 0 && idx + 1 < tr.size()) ? tr[idx + 1] : 16'hFFFF;
        total_cnt++;
        if (hits !== 1) $display("FAIL strobe_pulse_count: got %0d want 1 (uio=07 ui=F0)", hits); else pass_cnt++;
        total_cnt++;
        if (prev_v !== 16'h0000) $display("FAIL strobe_before: got %h want 0000", prev_v); else pass_cnt++;
        total_cnt++;
        if (next_v !== 16'h0000) $display("FAIL strobe_after: got %h want 0000", next_v); else pass_cnt++;
        collect(-1, 0);
        total_cnt++;
        if (rx_n !== 4) $display("FAIL strobe_drain: got %0d words want 4", rx_n); else pass_cnt++;
    endtask

    task automatic test_gaps();
        logic [15:0] st [$];
        logic [15:0] v;
        logic [7:0]  exp_uio;
        int stray;
        sel = 0;
        set_default_bytes();
        tr.delete();
        trace_en = 1'b1;
        send_txn(2);
        trace_en = 1'b0;
        stray = 0;
        for (int i = 0; i < tr.size(); i++) begin
            if (tr[i][8]) st.push_back(tr[i]);
            else if (tr[i] != 16'h0000) stray++;
        end
        total_cnt++;
        if (st.size() !== 8) $display("FAIL gaps_strobe_count: got %0d want 8", st.size()); else pass_cnt++;
        total_cnt++;
        if (stray !== 0) $display("FAIL gaps_idle_nonzero: got %0d cycles want 0", stray); else pass_cnt++;
        for (int j = 0; j < 8; j++) begin
            v       = (j < st.size()) ? st[j] : 16'hxxxx;
            exp_uio = 8'h01 | ((j >= 4) ? 8'h02 : 8'h00) | 8'((j % 4) * 4);
            total_cnt++;
            if (v !== {exp_uio, 8'(j + 1)}) $display("FAIL gaps_strobe%0d: got %h want %h", j, v, {exp_uio, 8'(j + 1)});
            else pass_cnt++;
        end
        collect(-1, 0);
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (rx_w[i] !== exp_w[i]) $display("FAIL gaps_word%0d: got %h want %h", i, rx_w[i], exp_w[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        sel = 0;
        set_default_bytes();
        send_txn(0);
        collect(1, 3);
        total_cnt++;
        if (rx_held !== 16'h4433) $display("FAIL bp_held: got %h want 4433", rx_held); else pass_cnt++;
        total_cnt++;
        if (rx_hold_ok !== 1'b1) $display("FAIL bp_stable: got %b want 1", rx_hold_ok); else pass_cnt++;
        total_cnt++;
        if (rx_n !== 4) $display("FAIL bp_count: got %0d words want 4", rx_n); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (rx_w[i] !== exp_w[i]) $display("FAIL bp_word%0d: got %h want %h", i, rx_w[i], exp_w[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (rx_busy_ok !== 1'b1) $display("FAIL bp_busy_held: got %b want 1", rx_busy_ok); else pass_cnt++;
        total_cnt++;
        if (c_busy !== 1'b0) $display("FAIL bp_busy_after: got %b want 0", c_busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit seen_rv, seen_le;
        sel = 0;
        set_default_bytes();
        send_txn(0);               // now in cycle T
        repeat (7) tick();          // cycle T+7 = capture cycle 3
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (c_op_ready !== 1'b1) $display("FAIL rmid_op_ready: got %b want 1", c_op_ready); else pass_cnt++;
        total_cnt++;
        if (c_busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", c_busy); else pass_cnt++;
        total_cnt++;
        if (c_res_valid !== 1'b0) $display("FAIL rmid_res_valid: got %b want 0", c_res_valid); else pass_cnt++;
        total_cnt++;
        if ({c_res_data, c_ui, c_uio} !== 32'h0)
            $display("FAIL rmid_data: got res=%h ui=%h uio=%h want 0", c_res_data, c_ui, c_uio);
        else pass_cnt++;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (c_op_ready !== 1'b1) $display("FAIL rmid_release_op_ready: got %b want 1", c_op_ready); else pass_cnt++;
        seen_rv = 1'b0; seen_le = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c_res_valid) seen_rv = 1'b1;
            if (c_uio[0]) seen_le = 1'b1;
            tick();
        end
        total_cnt++;
        if (seen_rv !== 1'b0) $display("FAIL rmid_stale_res_valid: got %b want 0", seen_rv); else pass_cnt++;
        total_cnt++;
        if (seen_le !== 1'b0) $display("FAIL rmid_stale_load_en: got %b want 0", seen_le); else pass_cnt++;
        send_txn(0);
        collect(-1, 0);
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (rx_w[i] !== exp_w[i]) $display("FAIL rmid_word%0d: got %h want %h", i, rx_w[i], exp_w[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_latency();
        for (int d = 1; d <= 2; d++) begin
            sel = d;
            set_default_bytes();
            tick();
            send_txn(0);
            collect(-1, 0);
            total_cnt++;
            if (rx_n !== 4) $display("FAIL lat%0d_count: got %0d words want 4", lat_of(d), rx_n); else pass_cnt++;
            for (int i = 0; i < 4; i++) begin
                total_cnt++;
                if (rx_w[i] !== exp_w[i])
                    $display("FAIL lat%0d_word%0d: got %h want %h", lat_of(d), i, rx_w[i], exp_w[i]);
                else pass_cnt++;
            end
        end
        sel = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_strobe_encoding();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        test_latency();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
